microwave_ctrl: RTL and testbench
=================================

MICROWAVE_CTRL -- requirements
Module: microwave_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100_000_000, clk cycles per cook second.
REQ-002 SHALL have parameter STEP_SEC, default 10, seconds added or removed per up/down press.
REQ-003 SHALL have parameter MAX_SEC, default 990, cook-time ceiling.
REQ-004 SHALL have parameter END_HOLD_SEC, default 3, seconds spent in COOK_END.
REQ-005 clk  in  1  system clock; one clock domain, all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 mode_active  in  1  high while the top-level mode is MICROWAVE; buttons are ignored when low.
REQ-008 btn_start, btn_stop, btn_up, btn_down  in  1 each  single-cycle debounced pulses.
REQ-009 door_open  in  1  level, high = door open.
REQ-010 oven_state  out  3  IDLE=000, READY=001, COOK=010, PAUSE=011, COOK_END=100.
REQ-011 remain_sec  out  10  remaining or programmed cook time, seconds.
REQ-012 door_history  out  2  bit0 = registered door_open; bit1 = door opened since last IDLE.
REQ-013 heater_on  out  1  high only in COOK.
REQ-014 end_pulse  out  1  one-cycle pulse on the cycle oven_state becomes COOK_END.

Function
REQ-015 All outputs SHALL be registered; state changes SHALL be visible on the cycle after the causing input.
REQ-016 Button priority SHALL be stop > start > up/down; up and down together SHALL be a no-op.
REQ-017 Up SHALL set remain_sec to min(remain_sec+STEP_SEC, MAX_SEC); down SHALL set it to max(remain_sec-STEP_SEC, 0); both are honoured only in IDLE and READY.
REQ-018 IDLE: up -> READY with the new time; start/stop/down -> no effect.
REQ-019 READY: start with door_open=0 -> COOK; start with door_open=1 -> ignored; stop -> IDLE with remain_sec=0; a down that reaches 0 -> IDLE.
REQ-020 COOK: prescaler counts 0..TICKS_PER_SEC-1; each wrap decrements remain_sec by 1.
REQ-021 COOK: a decrement that makes remain_sec 0 -> COOK_END with end_pulse.
REQ-022 COOK: door_open=1 or stop -> PAUSE; remain_sec is kept; a wrap on the same cycle SHALL NOT decrement.
REQ-023 PAUSE: prescaler holds its value; start with door closed -> COOK and counting resumes from the held value; stop -> IDLE with remain_sec=0.
REQ-024 COOK_END: prescaler restarts from 0; after END_HOLD_SEC wraps -> IDLE; stop or door_open rising edge -> IDLE at once.
REQ-025 Prescaler SHALL clear on entry to COOK from READY and on entry to IDLE.
REQ-026 door_history[1] SHALL set on any door_open rising edge outside IDLE and SHALL clear on entry to IDLE.
REQ-027 When mode_active=0, buttons SHALL be ignored, while the cook countdown and the door-driven COOK->PAUSE transition SHALL continue.
REQ-028 remain_sec SHALL never exceed MAX_SEC or wrap below 0.

Reset
REQ-029 On reset=1 at a clock edge: oven_state=IDLE, remain_sec=0, door_history=00, heater_on=0, end_pulse=0, prescaler=0.
REQ-030 Reset SHALL take priority over every input, including in mid-COOK.

Verification (TICKS_PER_SEC=4, STEP_SEC=10, MAX_SEC=990, END_HOLD_SEC=3)
REQ-031 Three up pulses, then start with door closed -> READY, remain_sec=30, then COOK with heater_on=1; after 120 cycles, end_pulse once, oven_state=100; 12 cycles later, IDLE.
REQ-032 Door opens during COOK at remain_sec=20 -> PAUSE, heater_on=0, door_history=11; start with door still open -> stays in PAUSE; close the door, then start -> COOK from 20.
REQ-033 100 up pulses -> remain_sec=990; one down -> 980; from READY at 10, down -> IDLE with remain_sec=0.
REQ-034 start and stop on the same cycle in READY -> IDLE with remain_sec=0; up and down on the same cycle -> remain_sec unchanged.
REQ-035 reset asserted mid-COOK -> all outputs at reset values on the next edge; a following start is ignored in IDLE.
REQ-036 mode_active=0 during COOK -> countdown continues, up/stop are ignored, and COOK_END is still reached.

Source files
------------

// File: rtl/microwave_ctrl.sv
// Microwave oven controller: button/door driven cook sequencer with a
// one-second prescaler, programmable cook time and end-of-cook hold.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no time programmed, waiting for an up press
// S_READY  | time programmed, waiting for start with the door closed
// S_COOK   | heater on, counting remain_sec down once per second
// S_PAUSE  | cook interrupted by door or stop, time and prescaler held
// S_END    | cook finished, holding END_HOLD_SEC seconds before IDLE
module microwave_ctrl #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int STEP_SEC      = 10,
    parameter int MAX_SEC       = 990,
    parameter int END_HOLD_SEC  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_active,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       door_open,
    output logic [2:0] oven_state,
    output logic [9:0] remain_sec,
    output logic [1:0] door_history,
    output logic       heater_on,
    output logic       end_pulse
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_READY = 3'b001,
        S_COOK  = 3'b010,
        S_PAUSE = 3'b011,
        S_END   = 3'b100
    } state_t;

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HW = (END_HOLD_SEC > 1) ? $clog2(END_HOLD_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(END_HOLD_SEC - 1);
    localparam logic [9:0]    STEP_R     = 10'(STEP_SEC);
    localparam logic [9:0]    MAX_R      = 10'(MAX_SEC);

    state_t          state_q, state_nxt;
    logic [PW-1:0]   presc_q, presc_nxt;
    logic [HW-1:0]   hold_q, hold_nxt;
    logic [9:0]      remain_nxt;
    logic            hist1_nxt;
    logic            heater_nxt;
    logic            pulse_nxt;

    logic            start, stop, up, down;
    logic            door_rise;
    logic            wrap;
    logic [10:0]     up_sum;
    logic [9:0]      up_val;
    logic [9:0]      dn_val;

    // Buttons only count while the microwave mode owns the front panel;
    // up and down together cancel each other out.
    assign start     = mode_active & btn_start;
    assign stop      = mode_active & btn_stop;
    assign up        = mode_active & btn_up & ~btn_down;
    assign down      = mode_active & btn_down & ~btn_up;
    assign door_rise = door_open & ~door_history[0];
    assign wrap      = (presc_q == PRESC_LAST);

    // Saturating time adjust, computed one bit wider so the ceiling check cannot wrap.
    assign up_sum = {1'b0, remain_sec} + {1'b0, STEP_R};
    assign up_val = (up_sum > {1'b0, MAX_R}) ? MAX_R : up_sum[9:0];
    assign dn_val = (remain_sec > STEP_R) ? (remain_sec - STEP_R) : 10'd0;

    assign oven_state = state_q;

    // Next-state, cook-time and prescaler decisions.
    always_comb begin
        state_nxt  = state_q;
        remain_nxt = remain_sec;
        presc_nxt  = presc_q;
        hold_nxt   = hold_q;
        case (state_q)
            S_IDLE: begin
                if (up) begin
                    state_nxt  = S_READY;
                    remain_nxt = up_val;
                end
            end
            S_READY: begin
                if (stop) begin
                    state_nxt  = S_IDLE;
                    remain_nxt = '0;
                end else if (start) begin
                    // a start with the door open is swallowed, not deferred
                    if (!door_open) begin
                        state_nxt = S_COOK;
                        presc_nxt = '0;
                    end
                end else if (up) begin
                    remain_nxt = up_val;
                end else if (down) begin
                    remain_nxt = dn_val;
                    if (dn_val == 10'd0) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_COOK: begin
                // pausing wins over a coincident wrap so no second is lost
                if (door_open || stop) begin
                    state_nxt = S_PAUSE;
                end else if (wrap) begin
                    presc_nxt = '0;
                    if (remain_sec <= 10'd1) begin
                        remain_nxt = '0;
                        state_nxt  = S_END;
                        hold_nxt   = '0;
                    end else begin
                        remain_nxt = remain_sec - 10'd1;
                    end
                end else begin
                    presc_nxt = presc_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_nxt  = S_IDLE;
                    remain_nxt = '0;
                end else if (start && !door_open) begin
                    state_nxt = S_COOK;
                end
            end
            S_END: begin
                if (stop || door_rise) begin
                    state_nxt = S_IDLE;
                end else if (wrap) begin
                    presc_nxt = '0;
                    if (hold_q == HOLD_LAST) begin
                        state_nxt = S_IDLE;
                    end else begin
                        hold_nxt = hold_q + 1'b1;
                    end
                end else begin
                    presc_nxt = presc_q + 1'b1;
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                remain_nxt = '0;
            end
        endcase

        if (state_nxt == S_IDLE) begin
            presc_nxt = '0;
        end

        hist1_nxt = door_history[1];
        if (state_nxt == S_IDLE) begin
            hist1_nxt = 1'b0;
        end else if (door_rise && (state_q != S_IDLE)) begin
            hist1_nxt = 1'b1;
        end

        heater_nxt = (state_nxt == S_COOK);
        pulse_nxt  = (state_nxt == S_END) && (state_q != S_END);
    end

    // State and output registers; reset overrides every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            remain_sec   <= '0;
            presc_q      <= '0;
            hold_q       <= '0;
            door_history <= '0;
            heater_on    <= 1'b0;
            end_pulse    <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            remain_sec   <= remain_nxt;
            presc_q      <= presc_nxt;
            hold_q       <= hold_nxt;
            door_history <= {hist1_nxt, door_open};
            heater_on    <= heater_nxt;
            end_pulse    <= pulse_nxt;
        end
    end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Bench for microwave_ctrl: directed scenarios plus random traffic, every
// cycle compared against a tick-level behavioural model of the oven.
module tb_microwave_ctrl;

    localparam int T    = 4;
    localparam int STEP = 10;
    localparam int MAXS = 990;
    localparam int HOLD = 3;

    localparam int M_IDLE  = 0;
    localparam int M_READY = 1;
    localparam int M_COOK  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_END   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_active;
    logic       btn_start, btn_stop, btn_up, btn_down;
    logic       door_open;
    logic [2:0] oven_state;
    logic [9:0] remain_sec;
    logic [1:0] door_history;
    logic       heater_on;
    logic       end_pulse;

    int checks   = 0;
    int failures = 0;

    // model: cook time held as ticks still to run, seconds shown rounded up
    int m_state, m_ticks, m_end_left, m_door, m_hist, m_heater, m_pulse;

    microwave_ctrl #(
        .TICKS_PER_SEC(T),
        .STEP_SEC(STEP),
        .MAX_SEC(MAXS),
        .END_HOLD_SEC(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode_active(mode_active),
        .btn_start(btn_start),
        .btn_stop(btn_stop),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .door_open(door_open),
        .oven_state(oven_state),
        .remain_sec(remain_sec),
        .door_history(door_history),
        .heater_on(heater_on),
        .end_pulse(end_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int sec_of(int ticks);
        return (ticks + T - 1) / T;
    endfunction

    task automatic model_step();
        int  nst;
        int  sec;
        bit  rise, st, sp, up, dn;
        if (reset) begin
            m_state = M_IDLE; m_ticks = 0; m_end_left = 0; m_door = 0;
            m_hist = 0; m_heater = 0; m_pulse = 0;
            return;
        end
        rise = door_open && !m_door;
        st   = mode_active && btn_start;
        sp   = mode_active && btn_stop;
        up   = mode_active && btn_up && !btn_down;
        dn   = mode_active && btn_down && !btn_up;
        nst  = m_state;
        case (m_state)
            M_IDLE: if (up) begin
                nst = M_READY;
                m_ticks = ((STEP < MAXS) ? STEP : MAXS) * T;
            end
            M_READY: begin
                if (sp) begin
                    nst = M_IDLE; m_ticks = 0;
                end else if (st) begin
                    if (!door_open) nst = M_COOK;
                end else if (up || dn) begin
                    sec = m_ticks / T;
                    if (up) sec = (sec + STEP > MAXS) ? MAXS : sec + STEP;
                    else    sec = (sec > STEP) ? sec - STEP : 0;
                    m_ticks = sec * T;
                    if (sec == 0) nst = M_IDLE;
                end
            end
            M_COOK: begin
                if (door_open || sp) nst = M_PAUSE;
                else begin
                    m_ticks--;
                    if (m_ticks == 0) begin
                        nst = M_END; m_end_left = HOLD * T;
                    end
                end
            end
            M_PAUSE: begin
                if (sp) begin
                    nst = M_IDLE; m_ticks = 0;
                end else if (st && !door_open) nst = M_COOK;
            end
            M_END: begin
                if (sp || rise) nst = M_IDLE;
                else begin
                    m_end_left--;
                    if (m_end_left == 0) nst = M_IDLE;
                end
            end
            default: nst = M_IDLE;
        endcase
        if (nst == M_IDLE && m_state != M_IDLE) m_hist = 0;
        else if (rise && m_state != M_IDLE) m_hist = 1;
        m_pulse  = (nst == M_END && m_state != M_END) ? 1 : 0;
        m_heater = (nst == M_COOK) ? 1 : 0;
        m_door   = door_open ? 1 : 0;
        m_state  = nst;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_state"},  {29'd0, oven_state},   m_state);
        chk({tag, "_remain"}, {22'd0, remain_sec},   sec_of(m_ticks));
        chk({tag, "_door"},   {30'd0, door_history}, {m_hist[0], m_door[0]});
        chk({tag, "_heater"}, {31'd0, heater_on},    m_heater);
        chk({tag, "_pulse"},  {31'd0, end_pulse},    m_pulse);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic press(input bit up, input bit dn, input bit st, input bit sp, input string tag);
        btn_up = up; btn_down = dn; btn_start = st; btn_stop = sp;
        cyc(tag);
        btn_up = 0; btn_down = 0; btn_start = 0; btn_stop = 0;
    endtask

    initial begin
        int  n;
        bit  reached;
        reset = 1; mode_active = 1; door_open = 0;
        btn_start = 0; btn_stop = 0; btn_up = 0; btn_down = 0;
        cyc("rst");
        cyc("rst");
        reset = 0;
        chk("rst_state", oven_state, 0);
        chk("rst_remain", remain_sec, 0);
        chk("rst_hist", door_history, 0);

        // three ups, cook 30 s to completion, end hold
        repeat (3) press(1, 0, 0, 0, "up3");
        chk("c1_ready", oven_state, 1);
        chk("c1_30", remain_sec, 30);
        press(0, 0, 1, 0, "c1_start");
        chk("c1_cook", oven_state, 2);
        chk("c1_heat", heater_on, 1);
        n = 0;
        repeat (119) begin
            cyc("c1_run");
            if (end_pulse) n++;
        end
        chk("c1_last", remain_sec, 1);
        cyc("c1_end");
        chk("c1_endst", oven_state, 4);
        chk("c1_pulse", end_pulse, 1);
        chk("c1_pulse_early", n, 0);
        cyc("c1_after");
        chk("c1_pulse_once", end_pulse, 0);
        repeat (10) cyc("c1_hold");
        chk("c1_still_end", oven_state, 4);
        cyc("c1_idle");
        chk("c1_idlest", oven_state, 0);

        // door pause and resume
        repeat (2) press(1, 0, 0, 0, "c2_up");
        press(0, 0, 1, 0, "c2_start");
        door_open = 1;
        cyc("c2_door");
        chk("c2_pause", oven_state, 3);
        chk("c2_heat", heater_on, 0);
        chk("c2_hist", door_history, 3);
        chk("c2_20", remain_sec, 20);
        press(0, 0, 1, 0, "c2_st_open");
        chk("c2_stay", oven_state, 3);
        door_open = 0;
        cyc("c2_close");
        press(0, 0, 1, 0, "c2_resume");
        chk("c2_cook", oven_state, 2);
        chk("c2_from20", remain_sec, 20);
        repeat (4) cyc("c2_run");
        chk("c2_19", remain_sec, 19);
        chk("c2_hist10", door_history, 2);
        press(0, 0, 0, 1, "c2_stop1");
        chk("c2_stop_pause", oven_state, 3);
        press(0, 0, 0, 1, "c2_stop2");
        chk("c2_stop_idle", oven_state, 0);
        chk("c2_stop_zero", remain_sec, 0);
        chk("c2_hist_clr", door_history, 0);

        // saturation and down to zero
        repeat (100) press(1, 0, 0, 0, "c3_up");
        chk("c3_max", remain_sec, 990);
        press(0, 1, 0, 0, "c3_dn");
        chk("c3_980", remain_sec, 980);
        press(0, 0, 0, 1, "c3_stop");
        press(1, 0, 0, 0, "c3_up10");
        press(0, 1, 0, 0, "c3_dn0");
        chk("c3_idle", oven_state, 0);
        chk("c3_zero", remain_sec, 0);

        // start+stop together, up+down together
        press(1, 0, 0, 0, "c4_up");
        press(0, 0, 1, 1, "c4_ss");
        chk("c4_idle", oven_state, 0);
        chk("c4_zero", remain_sec, 0);
        repeat (2) press(1, 0, 0, 0, "c4_up2");
        press(1, 1, 0, 0, "c4_ud");
        chk("c4_ud20", remain_sec, 20);
        chk("c4_udst", oven_state, 1);

        // reset mid-cook
        press(0, 0, 1, 0, "c5_start");
        repeat (5) cyc("c5_run");
        reset = 1;
        cyc("c5_rst");
        reset = 0;
        chk("c5_state", oven_state, 0);
        chk("c5_remain", remain_sec, 0);
        chk("c5_heat", heater_on, 0);
        press(0, 0, 1, 0, "c5_start_idle");
        chk("c5_ignored", oven_state, 0);

        // mode inactive during cook
        press(1, 0, 0, 0, "c6_up");
        press(0, 0, 1, 0, "c6_start");
        mode_active = 0;
        press(1, 0, 0, 0, "c6_up_ign");
        press(0, 0, 0, 1, "c6_stop_ign");
        chk("c6_cook", oven_state, 2);
        reached = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            cyc("c6_run");
            if (oven_state == 3'b100) reached = 1;
        end
        chk("c6_reached_end", reached, 1);
        mode_active = 1;
        press(0, 0, 0, 1, "c6_stop_end");
        chk("c6_idle", oven_state, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            btn_up    = ($urandom_range(0, 5) == 0);
            btn_down  = ($urandom_range(0, 11) == 0);
            btn_start = ($urandom_range(0, 7) == 0);
            btn_stop  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 24) == 0) door_open = ~door_open;
            if ($urandom_range(0, 99) == 0) mode_active = ~mode_active;
            reset = ($urandom_range(0, 599) == 0);
            cyc("rnd");
        end
        reset = 0;
        btn_up = 0; btn_down = 0; btn_start = 0; btn_stop = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
